// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: state, select, trap and opcode codes shared by the RV32I control sequencer and decoder
package rv32i_ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_UIMM = 2'd3;
  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_SYSTEM  = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [1:0] TRAP_BUS     = 2'd3;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
endpackage

// File: rtl/rv32i_control_fsm_if.sv
// rv32i_control_fsm_if: decoder flags, memory handshakes and datapath controls around the sequencer
interface rv32i_control_fsm_if;
  logic is_alu_reg, is_alu_imm, is_branch, is_jalr, is_jal;
  logic is_auipc, is_lui, is_load, is_store, is_system;
  logic branch_taken;
  logic imem_ready, dmem_ready;
  logic imem_req, dmem_req, dmem_we;
  logic ir_we, pc_we, rf_we;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic halted;
  logic [2:0] state_o;
  modport master (
    input  is_alu_reg, is_alu_imm, is_branch, is_jalr, is_jal,
    input  is_auipc, is_lui, is_load, is_store, is_system,
    input  branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
    output pc_sel, wb_sel, trap_cause, halted, state_o
  );
  modport slave (
    output is_alu_reg, is_alu_imm, is_branch, is_jalr, is_jal,
    output is_auipc, is_lui, is_load, is_store, is_system,
    output branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
    input  pc_sel, wb_sel, trap_cause, halted, state_o
  );
endinterface

// File: rtl/rv32i_wait_timer.sv
// rv32i_wait_timer: memory wait counter with clear, enable and terminal count at WAIT_MAX-1
module rv32i_wait_timer #(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    tc = cnt_q == WAIT_W'(WAIT_MAX - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rv32i_control_fsm.sv
// rv32i_control_fsm: multi-cycle RV32I sequencer; perf counters under RV32I_CTRL_PERF_COUNTERS_EN
module rv32i_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  rv32i_control_fsm_if.master bus
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);
  state_t state_q, state_d;
  logic [1:0] trap_q, trap_d;
  logic wait_clr, wait_en, wait_tc;
  logic [9:0] flags;
  rv32i_wait_timer #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) u_timer (
    .clk(clk), .rst(reset), .clr(wait_clr), .en(wait_en), .tc(wait_tc)
  );
  always_comb begin
    flags = {bus.is_alu_reg, bus.is_alu_imm, bus.is_branch, bus.is_jalr, bus.is_jal,
             bus.is_auipc, bus.is_lui, bus.is_load, bus.is_store, bus.is_system};
    state_d = state_q;
    trap_d = trap_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we = 1'b0;
    bus.ir_we = 1'b0;
    bus.pc_we = 1'b0;
    bus.rf_we = 1'b0;
    bus.pc_sel = PC_PLUS4;
    bus.wb_sel = WB_ALU;
    wait_en = 1'b0;
    case (state_q)
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_we = bus.imem_ready;
        wait_en = !bus.imem_ready;
        if (bus.imem_ready) state_d = DECODE;
        else if (wait_tc) begin
          state_d = HALT;
          trap_d = TRAP_BUS;
        end
      end
      DECODE: begin
        state_d = !$onehot(flags) || bus.is_system ? HALT : EXECUTE;
        trap_d = !$onehot(flags) ? TRAP_ILLEGAL : bus.is_system ? TRAP_SYSTEM : trap_q;
      end
      EXECUTE: begin
        bus.pc_we = bus.is_branch;
        bus.pc_sel = bus.is_branch && bus.branch_taken ? PC_BRANCH : PC_PLUS4;
        state_d = bus.is_branch ? FETCH : bus.is_load || bus.is_store ? MEM : WB;
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we = bus.is_store;
        bus.pc_we = bus.dmem_ready && bus.is_store;
        wait_en = !bus.dmem_ready;
        if (bus.dmem_ready) state_d = bus.is_store ? FETCH : WB;
        else if (wait_tc) begin
          state_d = HALT;
          trap_d = TRAP_BUS;
        end
      end
      WB: begin
        bus.rf_we = 1'b1;
        bus.pc_we = 1'b1;
        bus.wb_sel = bus.is_alu_reg || bus.is_alu_imm ? WB_ALU :
                     bus.is_load ? WB_LOAD :
                     bus.is_jal || bus.is_jalr ? WB_PC4 : WB_UIMM;
        bus.pc_sel = bus.is_jal ? PC_JAL : bus.is_jalr ? PC_JALR : PC_PLUS4;
        state_d = FETCH;
      end
      default: ;
    endcase
    if (reset) begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we = 1'b0;
      bus.ir_we = 1'b0;
      bus.pc_we = 1'b0;
      bus.rf_we = 1'b0;
      bus.pc_sel = PC_PLUS4;
      bus.wb_sel = WB_ALU;
    end
    wait_clr = reset || state_d != state_q;
    bus.halted = state_q == HALT;
    bus.trap_cause = trap_q;
    bus.state_o = state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      trap_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      trap_q <= trap_d;
    end
  end
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;
  always_comb begin
    cycle_d = cycle_q + 32'(state_q != HALT);
    instret_d = instret_q + 32'(bus.pc_we);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instret_q <= instret_d;
    end
  end
  assign cycle_count = cycle_q;
  assign instret_count = instret_q;
`endif
endmodule

// File: tb/tb_rv32i_control_fsm.sv
// tb_rv32i_control_fsm: randomized instruction stream checked cycle by cycle against a per-instruction timing model
module tb_rv32i_control_fsm;
  localparam int WM = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int cyc_m = 0;
  int ins_m = 0;
  rv32i_control_fsm_if bus ();
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
  rv32i_control_fsm #(.WAIT_MAX(WM), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .cycle_count(cycle_count), .instret_count(instret_count)
  );
`else
  rv32i_control_fsm #(.WAIT_MAX(WM), .WAIT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask
  function automatic logic [15:0] ex(int st, int ir, int dq, int dw, int iw, int pw, int ps,
                                     int rw, int ws, int h, int tc);
    return {3'(st), 1'(ir), 1'(dq), 1'(dw), 1'(iw), 1'(pw), 2'(ps), 1'(rw), 2'(ws), 1'(h), 2'(tc)};
  endfunction
  function automatic logic [15:0] obs();
    return {bus.state_o, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we,
            bus.pc_sel, bus.rf_we, bus.wb_sel, bus.halted, bus.trap_cause};
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic step(input logic ir, input logic dr, input logic [15:0] e, input string tag);
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    @(negedge clk);
    chk(tag, 32'(obs()), 32'(e));
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
    chk("cycle_count", cycle_count, 32'(cyc_m));
    chk("instret_count", instret_count, 32'(ins_m));
`endif
    if (e[15:13] != 3'd5) cyc_m++;
    if (e[8]) ins_m++;
    @(posedge clk);
    #1;
  endtask
  task automatic set_flags(input logic [9:0] fl);
    {bus.is_alu_reg, bus.is_alu_imm, bus.is_branch, bus.is_jalr, bus.is_jal,
     bus.is_auipc, bus.is_lui, bus.is_load, bus.is_store, bus.is_system} = fl;
  endtask
  task automatic do_reset(input bit chk_hold, input logic [15:0] hold);
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    if (chk_hold) chk("reset_hold", 32'(obs()), 32'(hold));
    @(posedge clk);
    #1;
    cyc_m = 0;
    ins_m = 0;
    @(negedge clk);
    chk("reset_state", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
    chk("reset_cycle", cycle_count, 32'd0);
    chk("reset_instret", instret_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic halt_seq(input int tc);
    for (int i = 0; i < 3; i++) step(rb(), rb(), ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, tc), "halt");
    do_reset(1'b1, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, tc));
  endtask
  task automatic run_instr(input int k, input int iw, input int dw, input bit tk);
    logic [9:0] fl;
    int a, b, pcs, wbs;
    bit br, jr, jl, ld, st;
    fl = 10'b10_0000_0000 >> (k > 9 ? 0 : k);
    if (k == 10) begin
      a = $urandom_range(0, 9);
      b = (a + $urandom_range(1, 9)) % 10;
      fl = rb() ? 10'd0 : (10'd1 << a) | (10'd1 << b);
    end
    set_flags(fl);
    bus.branch_taken = tk;
    br = k == 2;
    jr = k == 3;
    jl = k == 4;
    ld = k == 7;
    st = k == 8;
    pcs = jl ? 2 : jr ? 3 : 0;
    wbs = k <= 1 ? 0 : ld ? 1 : (jl || jr) ? 2 : 3;
    for (int i = 0; i < iw && i < WM; i++)
      step(1'b0, rb(), ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
    if (iw >= WM) begin
      halt_seq(3);
      return;
    end
    step(1'b1, rb(), ex(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fetch");
    step(rb(), rb(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    if (k == 10) begin
      halt_seq(2);
      return;
    end
    if (k == 9) begin
      halt_seq(1);
      return;
    end
    step(rb(), rb(), ex(2, 0, 0, 0, 0, br, (br && tk) ? 1 : 0, 0, 0, 0, 0), "execute");
    if (br) return;
    if (ld || st) begin
      for (int i = 0; i < dw && i < WM; i++)
        step(rb(), 1'b0, ex(3, 0, 1, st, 0, 0, 0, 0, 0, 0, 0), "mem_wait");
      if (dw >= WM) begin
        halt_seq(3);
        return;
      end
      step(rb(), 1'b1, ex(3, 0, 1, st, 0, st, 0, 0, 0, 0, 0), "mem");
      if (st) return;
    end
    step(rb(), rb(), ex(4, 0, 0, 0, 0, 1, pcs, 1, wbs, 0, 0), "writeback");
  endtask
  task automatic mem_reset();
    set_flags(10'b00_0000_0100);
    step(1'b1, 1'b0, ex(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fetch");
    step(1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    step(1'b0, 1'b0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "execute");
    step(1'b0, 1'b0, ex(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "mem_wait");
    do_reset(1'b1, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    set_flags('0);
    bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    do_reset(1'b0, '0);
    run_instr(0, 0, 0, 0);
    run_instr(7, 3, 2, 0);
    run_instr(2, 0, 0, 1);
    run_instr(2, 0, 0, 0);
    run_instr(9, 0, 0, 0);
    run_instr(8, 0, WM, 0);
    run_instr(8, 1, 0, 0);
    run_instr(4, 0, 0, 0);
    run_instr(3, 2, 0, 0);
    run_instr(6, 0, 0, 0);
    run_instr(5, 0, 0, 0);
    run_instr(1, 0, 0, 0);
    run_instr(0, WM, 0, 0);
    run_instr(10, 0, 0, 0);
    run_instr(7, 3, 3, 0);
    mem_reset();
    for (int n = 0; n < 200; n++)
      run_instr($urandom_range(0, 10),
                ($urandom % 10 == 0) ? WM : $urandom_range(0, 3),
                ($urandom % 10 == 0) ? WM : $urandom_range(0, 3), rb());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv32i_control_fsm.md
Name: rv32i_control_fsm

Overview:
- Multi-cycle sequencer for the RV32I core built on external instruction and data memories.
- Consumes the instruction-decoder opcode flags and sequences fetch, decode, execute, memory and writeback.
- Drives enables and selects for the PC, IR, register file and memory request handshakes.
- Sits between the decoder/ALU datapath and the two external memory ports.

Parameters:
- WAIT_MAX, 255, maximum cycles a memory request may wait for ready before a bus error is raised.
- WAIT_W, 8, width of the wait counter; must satisfy 2**WAIT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- is_alu_reg, is_alu_imm, is_branch, is_jalr, is_jal, is_auipc, is_lui, is_load, is_store, is_system  in  1 each  decoder opcode flags, valid from DECODE onward.
- branch_taken  in  1  comparator result, valid in EXECUTE.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write strobe, qualified by dmem_req.
- ir_we  out  1  latch instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  2  0 = PC+4, 1 = PC+Bimm, 2 = PC+Jimm, 3 = (rs1+Iimm)&~1.
- rf_we  out  1  register file write enable.
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = Uimm/AUIPC result.
- halted  out  1  core stopped (system instruction, illegal opcode or bus error).
- trap_cause  out  2  0 = none, 1 = system, 2 = illegal opcode, 3 = bus timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset: synchronous and active-high. On the next clock edge the FSM enters FETCH, the wait counter clears and all outputs are 0 except state_o = FETCH.
- Reset has priority over every other event, including mid-handshake. An outstanding request is dropped and no write occurs in that cycle.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - imem_req = 1 until imem_ready.
  - The cycle imem_ready = 1: ir_we = 1, next state DECODE.
  - The wait counter increments each cycle without ready. When it reaches WAIT_MAX: HALT, trap_cause = 3.
- DECODE: one cycle, no strobes.
  - No flag set, or more than one flag set: HALT, trap_cause = 2.
  - is_system: HALT, trap_cause = 1.
  - Otherwise: EXECUTE.
- EXECUTE: one cycle.
  - Branch: pc_we = 1; pc_sel = 1 if branch_taken, else 0. Next state FETCH.
  - Load or store: next state MEM.
  - All other legal instructions: next state WB.
- MEM:
  - dmem_req = 1 until dmem_ready; dmem_we = is_store.
  - Same wait-counter and timeout rule as FETCH.
  - On ready, store: pc_we = 1, pc_sel = 0, next state FETCH.
  - On ready, load: next state WB.
- WB: one cycle.
  - rf_we = 1 and pc_we = 1.
  - wb_sel: ALU for alu_reg/alu_imm; 1 for load; 2 for jal/jalr; 3 for lui/auipc.
  - pc_sel: 2 for jal, 3 for jalr, else 0.
  - Next state FETCH.
- HALT: absorbing state. All strobes are 0, halted = 1, trap_cause holds; only reset exits.
- Invariants:
  - pc_we is asserted exactly once per retired instruction.
  - rf_we and dmem_we are never asserted in the same cycle.
  - The wait counter clears on every state change.
- Minimum latencies with zero-wait memory (ready in the first request cycle): ALU/LUI/AUIPC/JAL/JALR 4 cycles; branch 3; store 4; load 5.
- Simultaneous imem_ready with timeout terminal count: ready wins.
- Ready asserted while not requesting: ignored.

Optional Feature:
- Macro: RV32I_CTRL_PERF_COUNTERS_EN.
- When defined, the block adds two outputs: cycle_count (32) and instret_count (32).
  - cycle_count increments every non-HALT cycle.
  - instret_count increments on every pc_we.
  - Both clear on reset and wrap modulo 2**32.
- When undefined, these ports and registers do not exist and all other behaviour is unchanged.

Decomposition:
- Shared package rv32i_ctrl_pkg holds:
  - the state encoding constants (FETCH = 0 … HALT = 5);
  - the pc_sel, wb_sel and trap_cause codes;
  - the opcode constants shared with the decoder.
- One natural sub-module: rv32i_wait_timer, the wait counter with clear/enable/terminal-count, instantiated once and shared by FETCH and MEM.

Test Plan:
- ADD with imem_ready in the first cycle: states FETCH→DECODE→EXECUTE→WB→FETCH; rf_we = 1 and pc_we = 1 in cycle 4 only; wb_sel = 0, pc_sel = 0.
- LW with imem_ready delayed 3 cycles and dmem_ready delayed 2: imem_req held 4 cycles; dmem_req held 3 cycles with dmem_we = 0; WB with wb_sel = 1; total 10 cycles.
- BEQ taken, then BNE not taken: pc_we in EXECUTE with pc_sel = 1, then pc_sel = 0; rf_we never asserted.
- ECALL (is_system): halted = 1 and trap_cause = 1 from the cycle after DECODE; all strobes 0 thereafter; reset returns to FETCH.
- dmem_ready never asserted during SW, WAIT_MAX = 4: HALT after 4 waiting cycles with trap_cause = 3; no pc_we.
- Reset asserted mid-MEM: next cycle state_o = FETCH, dmem_req = 0, no rf_we/pc_we. With RV32I_CTRL_PERF_COUNTERS_EN defined, cycle_count = 0 and instret_count = 0.
